cpu_controller: RTL and testbench
=================================

// Module: cpu_controller
// PURPOSE
//  Instruction register, decoder and Moore control FSM that drives the datapath's control inputs.
//  Holds one 16-bit instruction and sequences the datapath for MOV/ADD/CMP/AND/MVN, one step per clock.
//  Also supplies sximm8/sximm5. PC=0 and mdata=0 until memory stage exists.
//  Format: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] shift, [2:0] Rm, [7:0] imm8, [4:0] imm5.
// PARAMETERS
//  DATA_W      16  instruction / datapath word width
//  REG_ADDR_W   3  register-file address width
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous reset, active-low
//  load       in   1   capture instr into IR (honoured only while w=1)
//  instr      in   16  instruction word
//  s          in   1   start: begin executing IR contents (sampled only in WAIT)
//  w          out  1   1 = idle in WAIT, ready for load/s
//  err        out  1   one-cycle pulse: unsupported opcode/op decoded
//  readnum    out  3   regfile read address
//  writenum   out  3   regfile write address
//  write      out  1   regfile write enable
//  vsel       out  2   00 mdata, 01 sximm8, 10 PC, 11 datapath_out
//  loada/loadb/loadc/loads  out  1 each  register enables (A, B, C, status)
//  asel       out  1   1 = ALU A operand forced to 0
//  bsel       out  1   1 = ALU B operand = sximm5
//  shift      out  2   shifter control
//  ALUop      out  2   00 ADD, 01 SUB(CMP), 10 AND, 11 NOT B
//  sximm8     out  16  sign-extended imm8;  sximm5 out 16 sign-extended imm5 (combinational from IR)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=WAIT, IR=16'h0000; every control output 0, w=1, err=0. Mid-op reset aborts at once; no write.
//  - Outputs Moore-decoded from state + IR; any control not listed below for a state is 0.
//  - IR loads on clk edge when load=1 and state=WAIT; load ignored while w=0.
//  - load and s at the same edge: executes the OLD IR; new IR visible next op.
//  - WAIT: w=1. s=1 -> DECODE, else stay.
//  - DECODE: 110/10 -> WR_IMM; 110/00 -> GET_B; 101/00,01,10 -> GET_A; 101/11 -> GET_B;
//    other -> WAIT with err=1 for that cycle.
//  - WR_IMM: vsel=01, writenum=Rn, write=1 -> WAIT.
//  - GET_A: readnum=Rn, loada=1 -> GET_B.
//  - GET_B: readnum=Rm, loadb=1 -> EXEC.
//  - EXEC: shift=IR[4:3]; ALUop=IR[12:11] (MOV reg: ALUop=00, asel=1); bsel=0.
//    CMP: loads=1, loadc=0 -> WAIT. Others: loadc=1 -> WR_REG.
//  - WR_REG: vsel=11, writenum=Rd, write=1 -> WAIT.
//  - Busy cycles (w=0) after accepting s: MOV imm 2, MOV reg 4, MVN 4, CMP 4, ADD/AND 5. Illegal 1.
//  - s held high continuously: next op starts the edge after returning to WAIT.
// STRUCTURE
//  - Package cpu_pkg: state_t enum {WAIT,DECODE,GET_A,GET_B,EXEC,WR_REG,WR_IMM}.
//  - cpu_pkg also holds opcode/op constants (OPC_MOV=3'b110, OPC_ALU=3'b101) and ALUop/vsel encodings.
//  - One sub-module instr_decoder: IR -> opcode, op, Rn, Rd, Rm, shift, sximm8, sximm5 (combinational).
//  - IR register, state register and output decode live here.
// TESTING
//  - MOV R0,#7: load 16'hD007, s -> DECODE, WR_IMM (write=1, writenum=0, vsel=01, sximm8=16'h0007), w=1 after 2 busy cycles.
//  - MOV R1,#-8: 16'hD1F8 -> sximm8=16'hFFF8, writenum=1.
//  - ADD R2,R1,R0 LSL#1: 16'hA148 -> GET_A rd=1 loada; GET_B rd=0 loadb; EXEC loadc ALUop=00 shift=01; WR_REG writenum=2 vsel=11.
//  - CMP R1,R0: 16'hA900 -> EXEC loads=1 ALUop=01 loadc=0; no write; 4 busy cycles.
//  - MOV R3,R5: 16'hC065 -> GET_B readnum=5; EXEC asel=1 ALUop=00; WR_REG writenum=3.
//  - Illegal: 16'h0000 + s -> err pulses once, w=1 next cycle. load mid-ADD ignored; rst_n low in GET_B -> WAIT, write never 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the CPU controller: FSM states, opcode/op
// fields, ALU operation and writeback-source select codes.
package cpu_pkg;

  localparam int CPU_DATA_W     = 16;
  localparam int CPU_REG_ADDR_W = 3;

  typedef enum logic [2:0] {
    WAIT,
    DECODE,
    GET_A,
    GET_B,
    EXEC,
    WR_REG,
    WR_IMM
  } state_t;

  // Opcode field IR[15:13]
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // op field IR[12:11]
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // ALU operation select
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  // Register-file writeback source select
  localparam logic [1:0] VSEL_MDATA = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b01;
  localparam logic [1:0] VSEL_PC    = 2'b10;
  localparam logic [1:0] VSEL_DP    = 2'b11;

  // True for every opcode/op pair the controller knows how to sequence
  function automatic logic is_legal(input logic [2:0] opc, input logic [1:0] op);
    return (opc == OPC_MOV && (op == OP_MOV_IMM || op == OP_MOV_REG)) ||
           (opc == OPC_ALU);
  endfunction

endpackage

// File: rtl/cpu_instr_decoder.sv
// Combinational split of a 16-bit instruction word into its fields, plus the
// sign-extended 8-bit and 5-bit immediates.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int DATA_W     = CPU_DATA_W,
  parameter int REG_ADDR_W = CPU_REG_ADDR_W
) (
  input  logic [DATA_W-1:0]     ir_i,
  output logic [2:0]            opcode_o,
  output logic [1:0]            op_o,
  output logic [REG_ADDR_W-1:0] rn_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [REG_ADDR_W-1:0] rm_o,
  output logic [1:0]            shift_o,
  output logic [DATA_W-1:0]     sximm8_o,
  output logic [DATA_W-1:0]     sximm5_o
);

  assign opcode_o = ir_i[15:13];
  assign op_o     = ir_i[12:11];
  assign rn_o     = ir_i[10:8];
  assign rd_o     = ir_i[7:5];
  assign shift_o  = ir_i[4:3];
  assign rm_o     = ir_i[2:0];
  assign sximm8_o = {{(DATA_W-8){ir_i[7]}}, ir_i[7:0]};
  assign sximm5_o = {{(DATA_W-5){ir_i[4]}}, ir_i[4:0]};

endmodule

// File: rtl/cpu_controller.sv
// Instruction register, decoder and Moore control FSM. One datapath step per
// clock; outputs are a pure function of the current state and the instruction
// being executed.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int DATA_W     = CPU_DATA_W,
  parameter int REG_ADDR_W = CPU_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_W-1:0]     instr,
  input  logic                  s,
  output logic                  w,
  output logic                  err,
  output logic [REG_ADDR_W-1:0] readnum,
  output logic [REG_ADDR_W-1:0] writenum,
  output logic                  write,
  output logic [1:0]            vsel,
  output logic                  loada,
  output logic                  loadb,
  output logic                  loadc,
  output logic                  loads,
  output logic                  asel,
  output logic                  bsel,
  output logic [1:0]            shift,
  output logic [1:0]            ALUop,
  output logic [DATA_W-1:0]     sximm8,
  output logic [DATA_W-1:0]     sximm5
);

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       ir_q;   // architecturally visible IR
  logic [DATA_W-1:0]       ex_q;   // copy of IR taken when s is accepted
  logic [DATA_W-1:0]       dec_ir;
  logic [2:0]              opc;
  logic [1:0]              op;
  logic [REG_ADDR_W-1:0]   rn, rd, rm;
  logic [1:0]              sh;

  // A load coinciding with s updates ir_q but the running op works from ex_q,
  // so the old instruction executes and the new one waits for the next s.
  assign dec_ir = (state_q == WAIT) ? ir_q : ex_q;

  instr_decoder #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_dec (
    .ir_i     (dec_ir),
    .opcode_o (opc),
    .op_o     (op),
    .rn_o     (rn),
    .rd_o     (rd),
    .rm_o     (rm),
    .shift_o  (sh),
    .sximm8_o (sximm8),
    .sximm5_o (sximm5)
  );

  // Next-state selection from current state and decoded instruction
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT:   if (s) state_d = DECODE;
      DECODE: begin
        if (opc == OPC_MOV && op == OP_MOV_IMM)      state_d = WR_IMM;
        else if (opc == OPC_MOV && op == OP_MOV_REG) state_d = GET_B;
        else if (opc == OPC_ALU && op == OP_MVN)     state_d = GET_B;
        else if (opc == OPC_ALU)                     state_d = GET_A;
        else                                         state_d = WAIT;
      end
      GET_A:  state_d = GET_B;
      GET_B:  state_d = EXEC;
      EXEC:   state_d = (opc == OPC_ALU && op == OP_CMP) ? WAIT : WR_REG;
      WR_REG: state_d = WAIT;
      WR_IMM: state_d = WAIT;
      default: state_d = WAIT;
    endcase
  end

  // State, IR and execution copy; load/s are only honoured while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT;
      ir_q    <= '0;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == WAIT && load) ir_q <= instr;
      if (state_q == WAIT && s)    ex_q <= ir_q;
    end
  end

  // Moore output decode; anything not driven for a state stays 0
  always_comb begin
    w        = (state_q == WAIT);
    err      = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    vsel     = VSEL_MDATA;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = ALU_ADD;
    unique case (state_q)
      DECODE: err = !is_legal(opc, op);
      GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      EXEC: begin
        shift = sh;
        if (opc == OPC_MOV) begin
          ALUop = ALU_ADD;
          asel  = 1'b1;
        end else begin
          ALUop = op;
        end
        if (opc == OPC_ALU && op == OP_CMP) loads = 1'b1;
        else                                loadc = 1'b1;
      end
      WR_REG: begin
        vsel     = VSEL_DP;
        writenum = rd;
        write    = 1'b1;
      end
      WR_IMM: begin
        vsel     = VSEL_IMM8;
        writenum = rn;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed table, hand-written corner sequences and
// randomized traffic checked cycle by cycle against a plan-based model.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst_n, load, s;
  logic [15:0] instr;
  logic        w, err, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8, sximm5;

  cpu_controller dut (
    .clk(clk), .rst_n(rst_n), .load(load), .instr(instr), .s(s),
    .w(w), .err(err), .readnum(readnum), .writenum(writenum), .write(write),
    .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
    .sximm8(sximm8), .sximm5(sximm5)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        w, err;
    logic [2:0]  readnum, writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  shift, aluop;
    logic [15:0] sximm8, sximm5;
  } ctl_t;

  ctl_t act;
  assign act = {w, err, readnum, writenum, write, vsel, loada, loadb, loadc,
                loads, asel, bsel, shift, ALUop, sximm8, sximm5};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: list of expected busy cycles for the op in flight
  ctl_t        q[$];
  logic [15:0] ir_m = 16'h0000;
  bit          busy_m = 0;

  function automatic ctl_t blank(input logic [15:0] i, input logic idle);
    ctl_t c;
    c = '0;
    c.w      = idle;
    c.sximm8 = {{8{i[7]}}, i[7:0]};
    c.sximm5 = {{11{i[4]}}, i[4:0]};
    return c;
  endfunction

  task automatic plan(input logic [15:0] i);
    ctl_t c;
    logic [2:0] opc;
    logic [1:0] op;
    opc = i[15:13];
    op  = i[12:11];
    c = blank(i, 0);
    c.err = !((opc == 3'b110 && (op == 2'b10 || op == 2'b00)) || opc == 3'b101);
    q.push_back(c);
    if (opc == 3'b110 && op == 2'b10) begin
      c = blank(i, 0); c.write = 1; c.writenum = i[10:8]; c.vsel = 2'b01;
      q.push_back(c);
    end else if (!c.err) begin
      if (opc == 3'b101 && op != 2'b11) begin
        c = blank(i, 0); c.readnum = i[10:8]; c.loada = 1; q.push_back(c);
      end
      c = blank(i, 0); c.readnum = i[2:0]; c.loadb = 1; q.push_back(c);
      c = blank(i, 0); c.shift = i[4:3];
      if (opc == 3'b110) begin c.aluop = 2'b00; c.asel = 1; end
      else c.aluop = op;
      if (opc == 3'b101 && op == 2'b01) c.loads = 1; else c.loadc = 1;
      q.push_back(c);
      if (!(opc == 3'b101 && op == 2'b01)) begin
        c = blank(i, 0); c.write = 1; c.writenum = i[7:5]; c.vsel = 2'b11;
        q.push_back(c);
      end
    end
  endtask

  task automatic check(input string name, input ctl_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", name, $time, got, want);
    end
  endtask

  // Drive one cycle of inputs, advance the model, compare all outputs
  task automatic cyc(input logic ld, input logic st, input logic [15:0] ins, input string name);
    ctl_t e;
    load = ld; s = st; instr = ins;
    if (q.size() != 0) begin
      e = q.pop_front(); busy_m = 1;
    end else if (busy_m) begin
      e = blank(ir_m, 1); busy_m = 0;
    end else begin
      if (st) plan(ir_m);
      if (ld) ir_m = ins;
      if (q.size() != 0) begin e = q.pop_front(); busy_m = 1; end
      else e = blank(ir_m, 1);
    end
    @(posedge clk);
    #1;
    check(name, e);
  endtask

  typedef struct {
    logic [15:0] ins;
    int          busy;
    int          nwr;
    logic [2:0]  wn;
    logic [1:0]  vs;
    logic [15:0] sx8;
    int          nerr;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int busy, nwr, nerr;
    logic [2:0]  wn;
    logic [1:0]  vs;
    logic [15:0] sx;

    tbl[0] = '{16'hD007, 2, 1, 3'd0, 2'b01, 16'h0007, 0};
    tbl[1] = '{16'hD1F8, 2, 1, 3'd1, 2'b01, 16'hFFF8, 0};
    tbl[2] = '{16'hA148, 5, 1, 3'd2, 2'b11, 16'h0048, 0};
    tbl[3] = '{16'hA900, 4, 0, 3'd0, 2'b00, 16'h0000, 0};
    tbl[4] = '{16'hC065, 4, 1, 3'd3, 2'b11, 16'h0065, 0};
    tbl[5] = '{16'hB800, 4, 1, 3'd0, 2'b11, 16'h0000, 0};
    tbl[6] = '{16'hB0E2, 5, 1, 3'd7, 2'b11, 16'hFFE2, 0};
    tbl[7] = '{16'h0000, 1, 0, 3'd0, 2'b00, 16'h0000, 1};
    tbl[8] = '{16'hE000, 1, 0, 3'd0, 2'b00, 16'h0000, 1};
    tbl[9] = '{16'hC800, 1, 0, 3'd0, 2'b00, 16'h0000, 1};

    rst_n = 0; load = 0; s = 0; instr = 16'h0000;
    #12;
    check("reset", blank(16'h0000, 1));
    @(negedge clk);
    rst_n = 1;

    // Directed table: load, start, run to idle
    for (int k = 0; k < 10; k++) begin
      cyc(1, 0, tbl[k].ins, "tbl_load");
      cyc(0, 1, 16'h0000, "tbl_start");
      busy = 0; nwr = 0; nerr = 0; wn = 0; vs = 0; sx = 0;
      while (act.w == 1'b0 && busy < 12) begin
        busy++;
        if (act.err) nerr++;
        if (act.write) begin
          nwr++; wn = act.writenum; vs = act.vsel; sx = act.sximm8;
        end
        cyc(0, 0, 16'h0000, "tbl_run");
      end
      chk("tbl_busy", busy, tbl[k].busy);
      chk("tbl_nwrite", nwr, tbl[k].nwr);
      chk("tbl_nerr", nerr, tbl[k].nerr);
      if (tbl[k].nwr != 0) begin
        chk("tbl_wnum", {wn, vs}, {tbl[k].wn, tbl[k].vs});
        chk("tbl_sximm8", sx, tbl[k].sx8);
      end
    end

    // load and s on the same edge: old IR runs, new IR visible afterwards
    cyc(1, 0, 16'hD007, "ls_load");
    cyc(1, 1, 16'hD1F8, "ls_both");
    cyc(0, 0, 16'h0000, "ls_wr");
    chk("ls_writenum", act.writenum, 3'd0);
    chk("ls_sximm8_old", act.sximm8, 16'h0007);
    cyc(0, 0, 16'h0000, "ls_idle");
    chk("ls_sximm8_new", act.sximm8, 16'hFFF8);

    // load during ADD is ignored
    cyc(1, 0, 16'hA148, "mid_load");
    cyc(0, 1, 16'h0000, "mid_start");
    repeat (4) cyc(1, 0, 16'hD0FF, "mid_busy");
    cyc(0, 0, 16'h0000, "mid_idle");
    chk("mid_w", act.w, 1'b1);
    chk("mid_sximm8", act.sximm8, 16'h0048);

    // s held high: back-to-back MOV imm ops with one WAIT cycle between
    cyc(1, 0, 16'hD207, "sh_load");
    repeat (7) cyc(0, 1, 16'h0000, "sh_run");
    repeat (3) cyc(0, 0, 16'h0000, "sh_drain");

    // async reset while in GET_B aborts the ADD without a write
    cyc(1, 0, 16'hA148, "rst_load");
    cyc(0, 1, 16'h0000, "rst_dec");
    cyc(0, 0, 16'h0000, "rst_geta");
    cyc(0, 0, 16'h0000, "rst_getb");
    chk("rst_in_getb", act.loadb, 1'b1);
    #2 rst_n = 0;
    #1;
    check("rst_async", blank(16'h0000, 1));
    q.delete(); ir_m = 16'h0000; busy_m = 0;
    @(posedge clk); #1;
    check("rst_held", blank(16'h0000, 1));
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 16'h0000, "rst_after");
      chk("rst_nowrite", act.write, 1'b0);
    end

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      logic [15:0] r;
      logic [2:0]  opc;
      int          sel;
      r   = 16'($urandom);
      sel = $urandom_range(0, 9);
      opc = (sel < 4) ? 3'b110 : (sel < 8) ? 3'b101 : r[15:13];
      cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
          {opc, r[12:0]}, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
